// File: rtl/id_ex_operand_stage_if.sv
// id_ex_operand_stage_if: decoded-instruction, forwarding and EX-operand bundle for the ID/EX stage
interface id_ex_operand_stage_if #(
  parameter int SIZE = 32,
  parameter int REG_ADDR = 5
);
  logic                id_valid;
  logic [SIZE-1:0]     id_pc;
  logic [SIZE-1:0]     id_rs1_data;
  logic [SIZE-1:0]     id_rs2_data;
  logic [SIZE-1:0]     id_imm;
  logic [REG_ADDR-1:0] id_rs1;
  logic [REG_ADDR-1:0] id_rs2;
  logic [REG_ADDR-1:0] id_rd;
  logic [3:0]          id_operation;
  logic                id_alu_src_a;
  logic                id_alu_src_b;
  logic                id_reg_write;
  logic                id_mem_read;
  logic                id_mem_write;
  logic [REG_ADDR-1:0] exmem_rd;
  logic [REG_ADDR-1:0] memwb_rd;
  logic                exmem_reg_write;
  logic                memwb_reg_write;
  logic [SIZE-1:0]     exmem_result;
  logic [SIZE-1:0]     memwb_result;
  logic [SIZE-1:0]     ex_a;
  logic [SIZE-1:0]     ex_b;
  logic [SIZE-1:0]     ex_store_data;
  logic [3:0]          ex_operation;
  logic [REG_ADDR-1:0] ex_rd;
  logic                ex_reg_write;
  logic                ex_mem_read;
  logic                ex_mem_write;
  logic                ex_valid;
  logic                load_use_stall;
  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_operation, id_alu_src_a, id_alu_src_b, id_reg_write, id_mem_read, id_mem_write,
           exmem_rd, memwb_rd, exmem_reg_write, memwb_reg_write, exmem_result, memwb_result,
    input  ex_a, ex_b, ex_store_data, ex_operation, ex_rd, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_valid, load_use_stall
  );
  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_operation, id_alu_src_a, id_alu_src_b, id_reg_write, id_mem_read, id_mem_write,
           exmem_rd, memwb_rd, exmem_reg_write, memwb_reg_write, exmem_result, memwb_result,
    output ex_a, ex_b, ex_store_data, ex_operation, ex_rd, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_valid, load_use_stall
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX register with EX/MEM-MEM/WB forwarding, operand select and load-use bubbles
module id_ex_operand_stage #(
  parameter int SIZE = 32,
  parameter int REG_ADDR = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_i,
  input  logic                 flush_i,
  id_ex_operand_stage_if.slave bus
);
  typedef struct packed {
    logic [SIZE-1:0]     a;
    logic [SIZE-1:0]     b;
    logic [SIZE-1:0]     store_data;
    logic [3:0]          operation;
    logic [REG_ADDR-1:0] rd;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                valid;
  } ex_t;
  ex_t             ex_d, ex_q;
  logic [SIZE-1:0] fwd_rs1, fwd_rs2;
  logic            load_use;
  always_comb begin
    fwd_rs1 = (bus.exmem_reg_write && bus.exmem_rd != '0 && bus.exmem_rd == bus.id_rs1) ? bus.exmem_result :
              (bus.memwb_reg_write && bus.memwb_rd != '0 && bus.memwb_rd == bus.id_rs1) ? bus.memwb_result :
              bus.id_rs1_data;
    fwd_rs2 = (bus.exmem_reg_write && bus.exmem_rd != '0 && bus.exmem_rd == bus.id_rs2) ? bus.exmem_result :
              (bus.memwb_reg_write && bus.memwb_rd != '0 && bus.memwb_rd == bus.id_rs2) ? bus.memwb_result :
              bus.id_rs2_data;
    // rs2 match is deliberately conservative even when B takes the immediate
    load_use = ex_q.valid && ex_q.mem_read && ex_q.rd != '0 && bus.id_valid &&
               (bus.id_rs1 == ex_q.rd || bus.id_rs2 == ex_q.rd);
    ex_d = '0;
    if (!flush_i && !load_use) begin
      ex_d.a          = bus.id_alu_src_a ? bus.id_pc : fwd_rs1;
      ex_d.b          = bus.id_alu_src_b ? bus.id_imm : fwd_rs2;
      ex_d.store_data = fwd_rs2;
      ex_d.operation  = bus.id_operation;
      ex_d.rd         = bus.id_rd;
      ex_d.reg_write  = bus.id_valid && bus.id_reg_write;
      ex_d.mem_read   = bus.id_valid && bus.id_mem_read;
      ex_d.mem_write  = bus.id_valid && bus.id_mem_write;
      ex_d.valid      = bus.id_valid;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ex_q <= '0;
    else if (!stall_i) ex_q <= ex_d;
  end
  assign bus.ex_a           = ex_q.a;
  assign bus.ex_b           = ex_q.b;
  assign bus.ex_store_data  = ex_q.store_data;
  assign bus.ex_operation   = ex_q.operation;
  assign bus.ex_rd          = ex_q.rd;
  assign bus.ex_reg_write   = ex_q.reg_write;
  assign bus.ex_mem_read    = ex_q.mem_read;
  assign bus.ex_mem_write   = ex_q.mem_write;
  assign bus.ex_valid       = ex_q.valid;
  assign bus.load_use_stall = load_use;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: vector table with expected-result queue plus hand-written reset, load-use and stall/flush sequences
module tb_id_ex_operand_stage;
  typedef struct {
    logic        valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  op;
    logic        sa, sb, rw, mr, mw;
    logic [4:0]  exrd;
    logic        exw;
    logic [31:0] exres;
    logic [4:0]  mwrd;
    logic        mww;
    logic [31:0] mwres, ea, eb, esd;
  } vec_t;
  typedef struct {
    logic [31:0] a, b, sd;
    logic [4:0]  rd;
    logic [3:0]  op;
    logic        v, rw, mr, mw;
  } exp_t;
  logic clk = 0, rst = 1, stall = 0, flush = 0;
  int tests = 0, fails = 0;
  vec_t tbl[9];
  vec_t z, ld, use1, use2;
  exp_t q[$];
  exp_t e;
  always #5 clk = ~clk;
  id_ex_operand_stage_if #(.SIZE(32), .REG_ADDR(5)) bus();
  id_ex_operand_stage #(.SIZE(32), .REG_ADDR(5)) dut (
    .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush), .bus(bus)
  );
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h want=%h", n, act, exp);
    end
  endtask
  task automatic drive(vec_t t);
    bus.id_valid = t.valid; bus.id_pc = t.pc; bus.id_rs1_data = t.rs1d; bus.id_rs2_data = t.rs2d;
    bus.id_imm = t.imm; bus.id_rs1 = t.rs1; bus.id_rs2 = t.rs2; bus.id_rd = t.rd;
    bus.id_operation = t.op; bus.id_alu_src_a = t.sa; bus.id_alu_src_b = t.sb;
    bus.id_reg_write = t.rw; bus.id_mem_read = t.mr; bus.id_mem_write = t.mw;
    bus.exmem_rd = t.exrd; bus.exmem_reg_write = t.exw; bus.exmem_result = t.exres;
    bus.memwb_rd = t.mwrd; bus.memwb_reg_write = t.mww; bus.memwb_result = t.mwres;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    //          v  pc      rs1d     rs2d   imm          rs1 rs2 rd op sa sb rw mr mw exrd exw exres mwrd mww mwres  ea       eb           esd
    tbl[0] = '{1, 'h40,  7,       9,     0,           5,  6,  1, 0, 0, 0, 1, 0, 0, 0,   0,  0,    0,   0,  0,     7,       9,           9};
    tbl[1] = '{1, 'h44,  1,       2,     0,           3,  2,  2, 1, 0, 0, 1, 0, 0, 3,   1,  'h11, 3,   1,  'h22,  'h11,    2,           2};
    tbl[2] = '{1, 'h48,  1,       2,     0,           3,  2,  2, 1, 0, 0, 1, 0, 0, 3,   0,  'h11, 3,   1,  'h22,  'h22,    2,           2};
    tbl[3] = '{1, 'h4c,  0,       3,     0,           0,  1,  3, 2, 0, 0, 1, 0, 0, 0,   1,  'h33, 0,   1,  'h44,  0,       3,           3};
    tbl[4] = '{1, 'h100, 5,       1,     'hFFFFFFFC,  1,  7,  3, 2, 1, 1, 0, 0, 1, 7,   1,  9,    0,   0,  0,     'h100,   'hFFFFFFFC,  9};
    tbl[5] = '{1, 'h104, 1,       1,     0,           9,  8,  6, 3, 0, 0, 1, 0, 0, 9,   1,  'hAA, 8,   1,  'hBB,  'hAA,    'hBB,        'hBB};
    tbl[6] = '{1, 'h108, 'h1234,  'h77,  0,           10, 11, 7, 4, 0, 0, 1, 0, 0, 0,   0,  0,    10,  0,  'h99,  'h1234,  'h77,        'h77};
    tbl[7] = '{0, 'h10c, 5,       6,     0,           1,  2,  12, 5, 0, 0, 1, 1, 0, 0,  0,  0,    0,   0,  0,     5,       6,           6};
    tbl[8] = '{1, 'h110, 5,       0,     7,           12, 0,  13, 6, 0, 1, 1, 0, 0, 0,  0,  0,    0,   0,  0,     5,       7,           0};
    z = '{default: '0};
    ld = z; ld.valid = 1; ld.rd = 4; ld.rw = 1; ld.mr = 1; ld.rs1 = 1; ld.rs2 = 2; ld.rs1d = 'h31; ld.rs2d = 'h32; ld.op = 4'd7;
    use1 = z; use1.valid = 1; use1.rs1 = 5; use1.rs1d = 7; use1.rs2 = 4; use1.rs2d = 9; use1.rd = 8; use1.rw = 1;
    use2 = z; use2.valid = 1; use2.rs1 = 1; use2.rs1d = 'h10; use2.rs2 = 4; use2.rd = 8; use2.rw = 1; use2.mw = 1;
    drive(tbl[0]);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", bus.ex_valid, 0);
    chk("rst.a", bus.ex_a, 0);
    chk("rst.lu", bus.load_use_stall, 0);
    rst = 0;
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d.lu", i), bus.load_use_stall, 0);
      e.a = tbl[i].ea; e.b = tbl[i].eb; e.sd = tbl[i].esd; e.rd = tbl[i].rd; e.op = tbl[i].op;
      e.v = tbl[i].valid; e.rw = tbl[i].valid & tbl[i].rw; e.mr = tbl[i].valid & tbl[i].mr; e.mw = tbl[i].valid & tbl[i].mw;
      q.push_back(e);
      tick;
      if (q.size() == 0) begin
        tests++; fails++;
        $display("FAIL v%0d.queue got=empty want=entry", i);
      end else begin
        e = q.pop_front();
        chk($sformatf("v%0d.a", i), bus.ex_a, e.a);
        chk($sformatf("v%0d.b", i), bus.ex_b, e.b);
        chk($sformatf("v%0d.sd", i), bus.ex_store_data, e.sd);
        chk($sformatf("v%0d.rd", i), bus.ex_rd, e.rd);
        chk($sformatf("v%0d.op", i), bus.ex_operation, e.op);
        chk($sformatf("v%0d.valid", i), bus.ex_valid, e.v);
        chk($sformatf("v%0d.rw", i), bus.ex_reg_write, e.rw);
        chk($sformatf("v%0d.mr", i), bus.ex_mem_read, e.mr);
        chk($sformatf("v%0d.mw", i), bus.ex_mem_write, e.mw);
      end
    end
    // load in EX, consumer in ID, then asynchronous reset between edges
    drive(ld);
    tick;
    chk("ld.mr", bus.ex_mem_read, 1);
    drive(use1);
    #1;
    chk("ar.lu_before", bus.load_use_stall, 1);
    rst = 1;
    #1;
    chk("ar.valid", bus.ex_valid, 0);
    chk("ar.a", bus.ex_a, 0);
    chk("ar.b", bus.ex_b, 0);
    chk("ar.rd", bus.ex_rd, 0);
    chk("ar.op", bus.ex_operation, 0);
    chk("ar.rw", bus.ex_reg_write, 0);
    chk("ar.mr", bus.ex_mem_read, 0);
    chk("ar.lu_after", bus.load_use_stall, 0);
    rst = 0;
    tick;
    chk("ar.cap_a", bus.ex_a, 7);
    chk("ar.cap_b", bus.ex_b, 9);
    chk("ar.cap_valid", bus.ex_valid, 1);
    // load-use bubble then MEM/WB forwarding on replay
    drive(ld);
    tick;
    drive(use2);
    #1;
    chk("lu.req", bus.load_use_stall, 1);
    tick;
    chk("lu.bub_valid", bus.ex_valid, 0);
    chk("lu.bub_rw", bus.ex_reg_write, 0);
    chk("lu.bub_mw", bus.ex_mem_write, 0);
    chk("lu.bub_rd", bus.ex_rd, 0);
    bus.memwb_rd = 4; bus.memwb_reg_write = 1; bus.memwb_result = 'h55;
    #1;
    chk("lu.req_clear", bus.load_use_stall, 0);
    tick;
    chk("lu.fwd_b", bus.ex_b, 'h55);
    chk("lu.fwd_sd", bus.ex_store_data, 'h55);
    chk("lu.valid", bus.ex_valid, 1);
    // stall dominates flush, then flush bubbles once stall drops
    stall = 1; flush = 1;
    drive(tbl[5]);
    for (int c = 0; c < 2; c++) begin
      tick;
      chk($sformatf("sf%0d.valid", c), bus.ex_valid, 1);
      chk($sformatf("sf%0d.a", c), bus.ex_a, 'h10);
      chk($sformatf("sf%0d.b", c), bus.ex_b, 'h55);
      chk($sformatf("sf%0d.mw", c), bus.ex_mem_write, 1);
    end
    stall = 0;
    tick;
    chk("fl.valid", bus.ex_valid, 0);
    chk("fl.rw", bus.ex_reg_write, 0);
    chk("fl.mw", bus.ex_mem_write, 0);
    chk("fl.rd", bus.ex_rd, 0);
    flush = 0;
    tick;
    chk("post.a", bus.ex_a, 'hAA);
    chk("post.valid", bus.ex_valid, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
